disp_src_scheduler: RTL and testbench

Time-shares the two-digit seven-segment display between several result producers (ALU result, PC low byte, status flags, etc.). Each producer raises a request with an 8-bit value. The scheduler grants producers in round-robin order and holds each granted value on the display for a fixed dwell period. Its registered output drives the existing digit multiplexer's 8-bit value input, so the scheduler sits between the datapath sources and the display driver.

---
 rtl/disp_pkg.sv | 13 +
 rtl/disp_rr_pick.sv | 34 +++
 rtl/disp_src_scheduler.sv | 102 ++++++++++
 tb/tb_disp_src_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the display source scheduler.
package disp_pkg;

   localparam int DISP_VAL_W = 8;
   localparam int DISP_DWELL_DEFAULT = 50_000_000;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      SHOW
   } disp_sched_state_t;

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: searches from rr_ptr+1 upward, wrapping,
// so the most recently granted source is considered last.
module disp_rr_pick
   import disp_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] valid,
   input  logic [SRC_W-1:0]   rr_ptr,
   output logic [SRC_W-1:0]   winner,
   output logic               any_valid
);

   // Walk from the farthest offset to the nearest so the nearest valid
   // source (offset 1 from rr_ptr) is the last one written and wins.
   always_comb begin
      int idx;
      logic [SRC_W-1:0] sel;
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_SRC;
         sel = idx[SRC_W-1:0];
         if (valid[sel]) begin
            winner    = sel;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_src_scheduler.sv
// Round-robin time-sharing of the 8-bit display value between NUM_SRC producers.
// Optional macro DISP_SCHED_PRIORITY_EN makes source 0 pre-empt any other dwell.
module disp_src_scheduler
   import disp_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DWELL   = DISP_DWELL_DEFAULT,
   localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int CNT_W  = $clog2(DWELL)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC*DISP_VAL_W-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ack,
   input  logic                          hold,
   output logic [DISP_VAL_W-1:0]         disp_value,
   output logic [SRC_W-1:0]              disp_src,
   output logic                          disp_valid
);

   disp_sched_state_t state;
   logic [CNT_W-1:0]  cnt;
   logic [SRC_W-1:0]  rr_ptr;
   logic [SRC_W-1:0]  cap_idx;
   logic [SRC_W-1:0]  winner;
   logic              any_valid;
   logic              prio_hit;

   disp_rr_pick #(
      .NUM_SRC(NUM_SRC),
      .SRC_W  (SRC_W)
   ) u_pick (
      .valid    (src_valid),
      .rr_ptr   (rr_ptr),
      .winner   (winner),
      .any_valid(any_valid)
   );

`ifdef DISP_SCHED_PRIORITY_EN
   assign prio_hit = src_valid[0] && (disp_src != '0);
`else
   assign prio_hit = 1'b0;
`endif

   // src_ack is registered together with the move into CAPTURE, so it is
   // high for exactly the CAPTURE cycle; the display updates as CAPTURE ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         rr_ptr     <= SRC_W'(NUM_SRC - 1);
         cap_idx    <= '0;
         src_ack    <= '0;
         disp_value <= '0;
         disp_src   <= '0;
         disp_valid <= 1'b0;
      end else begin
         src_ack <= '0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  cap_idx <= winner;
                  src_ack <= NUM_SRC'(1) << winner;
                  state   <= CAPTURE;
               end
            end
            CAPTURE: begin
               disp_value <= src_data[DISP_VAL_W*int'(cap_idx) +: DISP_VAL_W];
               disp_src   <= cap_idx;
               disp_valid <= 1'b1;
               rr_ptr     <= cap_idx;
               cnt        <= '0;
               state      <= SHOW;
            end
            SHOW: begin
               if (prio_hit) begin
                  cap_idx <= '0;
                  src_ack <= NUM_SRC'(1);
                  state   <= CAPTURE;
               end else if (!hold) begin
                  if (cnt == CNT_W'(DWELL - 1)) begin
                     if (any_valid) begin
                        cap_idx <= winner;
                        src_ack <= NUM_SRC'(1) << winner;
                        state   <= CAPTURE;
                     end else begin
                        disp_valid <= 1'b0;
                        disp_value <= '0;
                        state      <= IDLE;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_src_scheduler.sv
// Scoreboard bench for disp_src_scheduler with NUM_SRC=4, DWELL=4.
// Expected grants follow DISP_SCHED_PRIORITY_EN when it is defined.
module tb_disp_src_scheduler;

   logic        clk;
   logic        rst_n;
   logic [3:0]  src_valid;
   logic [31:0] src_data;
   logic [3:0]  src_ack;
   logic        hold;
   logic [7:0]  disp_value;
   logic [1:0]  disp_src;
   logic        disp_valid;

   typedef struct {
      logic [3:0] ack;
      int         gap;
   } ack_exp_t;

   typedef struct {
      logic [7:0] value;
      logic [1:0] src;
   } disp_exp_t;

   ack_exp_t  ack_q[$];
   disp_exp_t disp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_ack_cyc = 0;
   bit ack_prev = 0;

   disp_src_scheduler #(
      .NUM_SRC(4),
      .DWELL  (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ack   (src_ack),
      .hold      (hold),
      .disp_value(disp_value),
      .disp_src  (disp_src),
      .disp_valid(disp_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ack(input logic [3:0] ack, input int gap);
      ack_exp_t e;
      e.ack = ack;
      e.gap = gap;
      ack_q.push_back(e);
   endtask

   task automatic push_disp(input logic [7:0] value, input logic [1:0] src);
      disp_exp_t e;
      e.value = value;
      e.src   = src;
      disp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      src_valid = '0;
      src_data  = '0;
      hold      = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_outputs", {src_ack, disp_value, disp_src, disp_valid}, 32'h0);
      rst_n = 1'b1;
      step(1);
   endtask

   // Monitor: every ack pops the grant queue; the cycle after an ack the
   // captured value must appear, which pops the display queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         ack_prev = 1'b0;
      end else begin
         if (ack_prev) begin
            if (disp_q.size() == 0) begin
               check("unexpected_display", {disp_value, 6'b0, disp_src}, 32'hFFFF_FFFF);
            end else begin
               disp_exp_t d;
               d = disp_q.pop_front();
               check("display", {disp_valid, disp_src, disp_value}, {1'b1, d.src, d.value});
            end
         end
         if (src_ack != '0) begin
            if (ack_q.size() == 0) begin
               check("unexpected_ack", {28'b0, src_ack}, 32'h0);
            end else begin
               ack_exp_t a;
               int gap;
               a = ack_q.pop_front();
               gap = (a.gap == 0) ? 0 : cyc - last_ack_cyc;
               check("ack_and_period", {gap[27:0], src_ack}, {a.gap[27:0], a.ack});
            end
            last_ack_cyc = cyc;
         end
         ack_prev = (src_ack != '0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      src_valid = '0;
      src_data  = '0;
      hold      = 1'b0;

      // Single source: latency, then all valids gone -> back to idle
      apply_reset();
      src_valid = 4'b0001;
      src_data[7:0] = 8'h2A;
      push_ack(4'b0001, 0);
      push_disp(8'h2A, 2'd0);
      step(1);
      check("ack_latency", {28'b0, src_ack}, 32'h1);
      check("no_display_yet", {31'b0, disp_valid}, 32'h0);
      src_valid = '0;
      step(1);
      check("display_latency", {disp_valid, disp_src, disp_value}, {1'b1, 2'd0, 8'h2A});
      step(3);
      check("still_showing", {31'b0, disp_valid}, 32'h1);
      step(1);
      check("idle_after_expiry", {disp_valid, disp_value}, 32'h0);

      // Four sources round-robin, then asynchronous reset mid-SHOW
      apply_reset();
      src_valid = 4'b1111;
      src_data  = {8'd40, 8'd30, 8'd20, 8'd10};
      push_ack(4'b0001, 0);
      push_ack(4'b0010, 5);
      push_ack(4'b0100, 5);
      push_ack(4'b1000, 5);
      push_ack(4'b0001, 5);
      push_disp(8'd10, 2'd0);
      push_disp(8'd20, 2'd1);
      push_disp(8'd30, 2'd2);
      push_disp(8'd40, 2'd3);
      push_disp(8'd10, 2'd0);
      step(23);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {src_ack, disp_value, disp_src, disp_valid}, 32'h0);

      // Lone source 2 re-sampled on the next grant
      apply_reset();
      src_valid = 4'b0100;
      src_data[23:16] = 8'd7;
      push_ack(4'b0100, 0);
      push_ack(4'b0100, 5);
      push_disp(8'd7, 2'd2);
      push_disp(8'd9, 2'd2);
      step(3);
      src_data[23:16] = 8'd9;
      step(2);
      check("dwell_not_resampled", {24'b0, disp_value}, 32'd7);
      step(2);
      check("resampled_value", {24'b0, disp_value}, 32'd9);
      src_valid = '0;
      step(6);
      check("idle_after_lone", {31'b0, disp_valid}, 32'h0);

      // hold for 10 cycles stretches the grant period from 5 to 15
      apply_reset();
      src_valid = 4'b0011;
      src_data[15:0] = {8'h22, 8'h11};
      push_ack(4'b0001, 0);
      push_ack(4'b0010, 15);
      push_disp(8'h11, 2'd0);
      push_disp(8'h22, 2'd1);
      step(3);
      hold = 1'b1;
      step(10);
      hold = 1'b0;
      step(3);
      src_valid = '0;
      step(6);
      check("idle_after_hold", {31'b0, disp_valid}, 32'h0);

      // Source 0 requests while source 3 is shown with hold asserted
      apply_reset();
      src_valid = 4'b1000;
      src_data[31:24] = 8'h33;
      push_ack(4'b1000, 0);
      push_disp(8'h33, 2'd3);
      step(2);
      hold = 1'b1;
      step(1);
      src_valid = 4'b1001;
      src_data[7:0] = 8'h44;
`ifdef DISP_SCHED_PRIORITY_EN
      push_ack(4'b0001, 3);
      push_disp(8'h44, 2'd0);
      step(2);
      hold = 1'b0;
      src_valid = '0;
      step(6);
`else
      push_ack(4'b0001, 15);
      push_disp(8'h44, 2'd0);
      step(1);
      check("no_preempt", {28'b0, src_ack}, 32'h0);
      step(8);
      hold = 1'b0;
      step(5);
      src_valid = '0;
      step(6);
`endif
      check("idle_after_urgent", {31'b0, disp_valid}, 32'h0);

      check("ack_queue_drained", ack_q.size(), 32'd0);
      check("disp_queue_drained", disp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
